// File: rtl/demux16_pkg.sv
// rtl/demux16_pkg.sv - shared constants, select type and select decode for demux16_buf
package demux16_pkg;

   localparam int CHANNELS = 16;
   localparam int SEL_W    = 4;

   typedef logic [SEL_W-1:0] sel_t;

   // One-hot decode of a channel index.
   function automatic logic [CHANNELS-1:0] decode_sel(input sel_t sel);
      decode_sel = CHANNELS'(1) << sel;
   endfunction

endpackage

// File: rtl/demux16_buf_if.sv
// rtl/demux16_buf_if.sv - producer/consumer bundle for demux16_buf; in_bcast exists only with DEMUX16_BROADCAST_EN
interface demux16_buf_if #(parameter int N = 32);
   import demux16_pkg::*;

   logic [N-1:0]                in_data;
   sel_t                        in_sel;
   logic                        in_valid;
   logic                        in_ready;
   logic [CHANNELS-1:0][N-1:0]  out_data;
   logic [CHANNELS-1:0]         out_valid;
   logic [CHANNELS-1:0]         out_ready;
`ifdef DEMUX16_BROADCAST_EN
   logic                        in_bcast;
`endif

   // Producer and consumers drive this side.
   modport master (
      output in_data, in_sel, in_valid, out_ready,
`ifdef DEMUX16_BROADCAST_EN
      output in_bcast,
`endif
      input  in_ready, out_data, out_valid
   );

   // The demux itself.
   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
`ifdef DEMUX16_BROADCAST_EN
      input  in_bcast,
`endif
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry valid/ready holding register for a single demux channel
module demux_slot #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [N-1:0] wr_data,
   input  logic         rd_ready,
   output logic         full,
   output logic [N-1:0] rd_data,
   output logic         can_take
);

   logic         full_q, full_d;
   logic [N-1:0] data_q, data_d;

   // Next state: a write wins over a same-cycle pop so the slot stays full with fresh data.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (wr_en) begin
         full_d = 1'b1;
         data_d = wr_data;
      end else if (full_q && rd_ready) begin
         full_d = 1'b0;
      end
   end

   // State register; reset discards the held word immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full     = full_q;
   assign rd_data  = data_q;
   assign can_take = ~full_q | rd_ready;

endmodule

// File: rtl/demux16_buf.sv
// rtl/demux16_buf.sv - buffered 1-to-16 valid/ready demux; optional broadcast with DEMUX16_BROADCAST_EN
module demux16_buf
   import demux16_pkg::*;
#(
   parameter int N = 32
) (
   input  logic             clk,
   input  logic             rst,
   demux16_buf_if.slave     bus
);

   logic [CHANNELS-1:0]         full_v;
   logic [CHANNELS-1:0]         can_take_v;
   logic [CHANNELS-1:0]         wr_en_v;
   logic [CHANNELS-1:0]         sel_dec;
   logic [CHANNELS-1:0][N-1:0]  data_v;
   logic                        bcast;
   logic                        in_ready;

   // Select decode, readiness and per-channel write enables; a broadcast writes all or nothing.
   always_comb begin
      sel_dec = decode_sel(bus.in_sel);
`ifdef DEMUX16_BROADCAST_EN
      bcast = bus.in_bcast;
`else
      bcast = 1'b0;
`endif
      if (bcast) begin
         in_ready = &can_take_v;
      end else begin
         in_ready = can_take_v[bus.in_sel];
      end
      wr_en_v = '0;
      if (bus.in_valid && in_ready) begin
         wr_en_v = bcast ? {CHANNELS{1'b1}} : sel_dec;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
      demux_slot #(.N(N)) u_slot (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en_v[k]),
         .wr_data  (bus.in_data),
         .rd_ready (bus.out_ready[k]),
         .full     (full_v[k]),
         .rd_data  (data_v[k]),
         .can_take (can_take_v[k])
      );
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = full_v;
   assign bus.out_data  = data_v;

endmodule

// File: doc/demux16_buf.md
# demux16_buf

Buffered 1-to-16 demultiplexer: the write-side counterpart to the 16-way read-select mux. It routes one valid/ready input stream to one of sixteen output channels chosen by a 4-bit select. Each channel has a one-entry holding register, so a stalled destination never corrupts the other fifteen. It sits between a single producer, such as an ALU result or bus response, and up to sixteen independent consumers.

## Interface
- N, default 32: data width of the input and of each channel.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N  payload to route.
- in_sel  input  4  destination channel index, 0..15.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offer this cycle.
- out_data  output  16×N (packed [15:0][N-1:0])  per-channel held payload.
- out_valid  output  16  channel k holds a payload.
- out_ready  input  16  consumer k takes its payload this cycle.
- in_bcast  input  1  broadcast request; this port exists only with DEMUX16_BROADCAST_EN.

## Operation
- Per channel k: state bit full[k] and register data[k]. out_valid[k] = full[k]; out_data[k] = data[k].
- Pop: pop[k] = full[k] & out_ready[k].
- Readiness: in_ready = ~full[in_sel] | out_ready[in_sel]. A full channel that is popping in the same cycle can accept new data.
- Accept: acc = in_valid & in_ready. On acc, data[in_sel] <= in_data and full[in_sel] <= 1.
- Channel k ≠ in_sel: a pop clears full[k]. Its data register is unchanged.
- Same-cycle accept and pop on one channel: the channel stays full with the new data. Back-to-back throughput is 1 word/cycle per channel.
- Different channels operate fully independently. Any mix of pops across all 16 channels can occur in one cycle alongside one accept.
- in_sel is ignored when in_valid = 0. in_ready is still driven from in_sel and may toggle; the producer must not depend on this.
- Producer rule: in_data and in_sel must stay stable while in_valid=1 and in_ready=0. Consumer rule: out_data[k] is stable while out_valid[k]=1 until popped.
- Every output is combinational from registered state, except in_ready. in_ready depends combinationally on in_sel, and on out_ready when the channel is full.

## Timing
- Reset: full = 0 for all channels and data = 0 for all channels. The resulting outputs are out_valid = 16'h0000, out_data = 0, and in_ready = 1.
- Reset asserted mid-operation discards all held words immediately, asynchronously. The first accept is possible on the first rising edge after rst deasserts.
- Latency is 1 cycle: a word accepted at edge t appears with out_valid[k]=1 after edge t. The earliest pop is at edge t+1.
- There is no combinational path from in_data to out_data.

## Configuration
- DEMUX16_BROADCAST_EN defined:
  - The in_bcast port is present.
  - When in_bcast=1, in_sel is ignored. in_ready = AND over k of (~full[k] | out_ready[k]).
  - On accept, all 16 channels load in_data and set full.
  - A broadcast is all-or-nothing; it never partially writes.
- DEMUX16_BROADCAST_EN undefined: the in_bcast port and its logic are absent, and behaviour is unicast only.

## Structure
- Package demux16_pkg: CHANNELS = 16, SEL_W = 4, and typedef sel_t = logic [SEL_W-1:0].
- Sub-module demux_slot #(N):
  - Holds one-entry valid/ready storage: full flag, data register, and async reset.
  - Ports: clk, rst, wr_en, wr_data, rd_ready, full, rd_data, can_take (= ~full | rd_ready).
  - Instantiated 16 times via generate.
- The top level holds the 4-to-16 select decode, the in_ready select, and the broadcast AND-reduce.

## Test plan
- Reset: assert rst mid-stream with channels 3 and 9 full. Expect out_valid=16'h0000 immediately, without waiting for a clock edge, and in_ready=1.
- Single route: in_sel=5, in_data=32'hDEADBEEF, out_ready=0. Expect out_valid=16'h0020 next cycle and out_data[5]=32'hDEADBEEF. All other channels stay empty.
- Backpressure on one channel:
  - Setup: channel 5 full with out_ready[5]=0.
  - Offer in_sel=5: expect in_ready=0 and the data held.
  - Offer in_sel=6, 32'h12345678: expect acceptance and out_valid=16'h0060.
- Pass-through streaming: channel 2 is full and out_ready[2]=1 every cycle. Send 8 words 1..8 to channel 2. Expect in_ready=1 every cycle and out_data[2] to step 1..8 on consecutive cycles with no bubbles.
- Concurrent pops: fill channels 0..15 with values k+100. Raise out_ready=16'hFFFF for one cycle while accepting in_sel=7, 32'hAAAA. Expect only out_valid[7]=1 afterwards, holding 32'hAAAA.
- Broadcast (with DEMUX16_BROADCAST_EN):
  - in_bcast=1 with channel 11 full and stalled: expect in_ready=0.
  - Release out_ready[11]: expect acceptance and out_valid=16'hFFFF with all channels holding the broadcast word.
